// File: rtl/phase_seq_monitor.sv
// phase_seq_monitor: tracks a rotating one-hot phase, locks after LOCK_N advances and counts rotations.
// Define PHASE_MON_REV_EN to also accept and count reverse rotation.
module phase_seq_monitor #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       phase_in,
    input  logic             clr_err,
    output logic [1:0]       phase_idx,
    output logic             phase_vld,
    output logic             locked,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             cycle_done,
    output logic             seq_err,
    output logic [1:0]       err_code,
    output logic             dir
);
    typedef enum logic [1:0] {SYNC, TRACK, LOCKED, FAULT} state_t;
    state_t state, state_nxt;
    logic [3:0] last, last_nxt;
    logic [2:0] good, good_nxt;
    logic [1:0] err_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic done_nxt, zero, onehot, hold, fwd, adv, flip, wrap, down;
    assign zero   = phase_in == 4'd0;
    assign onehot = !zero && (phase_in & (phase_in - 4'd1)) == 4'd0;
    assign hold   = zero || phase_in == last;
    assign fwd    = phase_in == {last[2:0], last[3]};
`ifdef PHASE_MON_REV_EN
    logic rev, dir_nxt;
    assign rev     = phase_in == {last[0], last[3:1]};
    assign adv     = dir ? rev : fwd;
    assign flip    = dir ? fwd : rev;
    assign down    = dir;
    assign wrap    = dir ? last == 4'b0001 && phase_in == 4'b1000 : last == 4'b1000 && phase_in == 4'b0001;
    assign dir_nxt = state == TRACK && flip ? !dir : dir;
`else
    assign adv  = fwd;
    assign flip = 1'b0;
    assign down = 1'b0;
    assign wrap = last == 4'b1000 && phase_in == 4'b0001;
    assign dir  = 1'b0;
`endif
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        good_nxt  = good;
        err_nxt   = err_code;
        cnt_nxt   = cycle_cnt;
        done_nxt  = 1'b0;
        if (state == FAULT) begin
            state_nxt = clr_err ? SYNC : FAULT;
            err_nxt   = clr_err ? 2'b00 : err_code;
        end else if (!zero && !onehot) begin
            state_nxt = FAULT;
            err_nxt   = 2'b01;
        end else if (!hold) begin
            if (state == LOCKED) begin
                state_nxt = adv ? LOCKED : FAULT;
                err_nxt   = adv ? err_code : 2'b10;
                last_nxt  = adv ? phase_in : last;
                done_nxt  = wrap;
                cnt_nxt   = !wrap ? cycle_cnt : down ? cycle_cnt - CNT_W'(1) : cycle_cnt + CNT_W'(1);
            end else begin
                // an opposite-direction advance counts as the first step of the new direction
                last_nxt  = phase_in;
                good_nxt  = state == TRACK && adv ? good + 3'd1 : state == TRACK && flip ? 3'd1 : 3'd0;
                state_nxt = state == TRACK && good_nxt == 3'(LOCK_N) ? LOCKED : TRACK;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= SYNC;
            last       <= '0;
            good       <= '0;
            phase_idx  <= '0;
            phase_vld  <= 1'b0;
            locked     <= 1'b0;
            cycle_cnt  <= '0;
            cycle_done <= 1'b0;
            seq_err    <= 1'b0;
            err_code   <= '0;
`ifdef PHASE_MON_REV_EN
            dir        <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            good       <= good_nxt;
            phase_vld  <= onehot;
            locked     <= state_nxt == LOCKED;
            cycle_cnt  <= cnt_nxt;
            cycle_done <= done_nxt;
            seq_err    <= state_nxt == FAULT;
            err_code   <= err_nxt;
            if (onehot && state != FAULT)
                phase_idx <= {phase_in[3] | phase_in[2], phase_in[3] | phase_in[1]};
`ifdef PHASE_MON_REV_EN
            dir        <= dir_nxt;
`endif
        end
    end
endmodule

// File: doc/phase_seq_monitor.md
PHASE_SEQ_MONITOR -- requirements
Module: phase_seq_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the rotation cycle counter.
REQ-002 Parameter LOCK_N, default 2, legal 1..7: consecutive correct phase advances needed to lock.
REQ-003 clk  in  1  rising-edge clock; the only clock.
REQ-004 rst  in  1  reset; synchronous, active-low.
REQ-005 phase_in  in  4  phase code from the upstream one-hot phase sequencer; 0000 is the idle gap.
REQ-006 clr_err  in  1  clears a latched fault; acts only in FAULT.
REQ-007 phase_idx  out  2  binary index of the last accepted one-hot phase: 0001=0, 0010=1, 0100=2, 1000=3.
REQ-008 phase_vld  out  1  high when the previous-cycle phase_in was one-hot.
REQ-009 locked  out  1  high while the FSM is in LOCKED.
REQ-010 cycle_cnt  out  CNT_W  count of full rotations completed while locked.
REQ-011 cycle_done  out  1  one-cycle pulse per completed rotation.
REQ-012 seq_err  out  1  sticky fault flag; high while in FAULT.
REQ-013 err_code  out  2  fault cause: 01 = illegal code, 10 = out-of-order; 00 otherwise.
REQ-014 dir  out  1  tracked direction: 0 = forward (0001 to 0010), 1 = reverse.

Function
REQ-015 All outputs are registered and reflect the phase_in sampled at the previous rising edge, giving one-cycle latency.
REQ-016 Classification of phase_in:
- ZERO = 0000.
- ONEHOT = exactly one bit set.
- ILLEGAL = any other code.
REQ-017 Internal state:
- last: the most recent ONEHOT phase.
- good: a 3-bit advance counter.
- FSM states: SYNC, TRACK, LOCKED, FAULT.
REQ-018 Forward advance means the input equals last rotated left by one (1000 wraps to 0001). Reverse advance means last rotated right by one.
REQ-019 ZERO, or ONEHOT equal to last, is a hold: last, good, state and counters are unchanged.
REQ-020 ILLEGAL in SYNC, TRACK or LOCKED: go to FAULT with err_code=01.
REQ-021 In SYNC, a ONEHOT input loads last, sets good=0 and moves to TRACK.
REQ-022 In TRACK, an advance in the current direction sets good+1 and updates last. When good+1 equals LOCK_N, move to LOCKED.
REQ-023 In TRACK, any other non-hold ONEHOT input loads last, sets good=0 and stays in TRACK; no error is raised.
REQ-024 In LOCKED, an advance in the current direction updates last.
REQ-025 In LOCKED, any other non-hold ONEHOT input goes to FAULT with err_code=10.
REQ-026 In LOCKED, a forward transition 1000 to 0001 (ZERO gaps allowed between them) pulses cycle_done and increments cycle_cnt. The counter wraps modulo 2^CNT_W and still pulses at the wrap.
REQ-027 In FAULT, phase_in is ignored and seq_err=1. When clr_err=1, go to SYNC with seq_err=0 and err_code=00. The input sampled in that same cycle is discarded.
REQ-028 cycle_cnt holds its value through FAULT and SYNC; only reset clears it.
REQ-029 phase_idx updates only on ONEHOT input and otherwise holds its value.

Reset
REQ-030 When rst=0 at a rising edge, the block enters SYNC and clears all outputs and internal state to 0, overriding every other input, including mid-rotation and in FAULT.

Configuration
REQ-031 With macro PHASE_MON_REV_EN defined, reverse advances are legal:
- In TRACK, a reverse advance sets dir=1 and good=1.
- In LOCKED, direction is fixed by dir.
- In LOCKED with dir=1, the transition 0001 to 1000 pulses cycle_done and decrements cycle_cnt, wrapping modulo 2^CNT_W.
REQ-032 Without PHASE_MON_REV_EN, dir is constant 0, a reverse advance is treated as out-of-order, and no reverse-only logic is synthesized.

Verification
REQ-033 Lock-up and count: after reset, drive 0000,0001,0010,0100,1000,0000,0001 (LOCK_N=2). Required response:
- locked=1 one cycle after 0100 is sampled.
- cycle_done pulses once, one cycle after the final 0001.
- cycle_cnt=1.
REQ-034 Illegal code: while locked, drive 0110. Required response:
- Next cycle: seq_err=1, err_code=01, locked=0.
- Further inputs are ignored.
- clr_err=1 then returns the block to SYNC with seq_err=0.
REQ-035 Out-of-order: while locked at 0010, drive 1000. Required response: err_code=10 next cycle, and cycle_cnt is unchanged.
REQ-036 Wrap: with CNT_W=2, complete 4 locked rotations. Required response: cycle_cnt sequence 1,2,3,0, with cycle_done pulsing 4 times.
REQ-037 Reset mid-operation: assert rst=0 for one cycle while locked with cycle_cnt=3. Required response:
- All outputs are 0 the next cycle.
- The block relocks only after LOCK_N new advances.
REQ-038 Reverse tracking (PHASE_MON_REV_EN defined): drive 1000,0100,0010,0001,1000. Required response:
- dir=1 and locked=1.
- cycle_cnt decrements from 0 to all-ones.
- Without the macro, the same stimulus never locks and raises no fault.
